// File: rtl/inv_mix_column_ctrl_if.sv
// Column stream interface for the InvMixColumns sequencer.
// Carries the input column handshake (inValid/inReady/inColumn) and the
// result column handshake (outValid/outReady/outColumn).
//   master : the side that produces input columns and consumes results
//   slave  : the transform block itself
interface inv_mix_column_ctrl_if;
  logic        inValid;
  logic        inReady;
  logic [31:0] inColumn;
  logic        outValid;
  logic        outReady;
  logic [31:0] outColumn;

  modport master (
    output inValid,
    output inColumn,
    output outReady,
    input  inReady,
    input  outValid,
    input  outColumn
  );

  modport slave (
    input  inValid,
    input  inColumn,
    input  outReady,
    output inReady,
    output outValid,
    output outColumn
  );
endinterface

// File: rtl/inv_mix_column_ctrl.sv
// AES InvMixColumns single-column sequencer.
// Takes one 32-bit column, looks up the x14/x11/x13/x9 products of every
// operand byte through four shared GF(2^8) multiply ROMs, XORs them into
// the result bytes and hands the finished column out with valid/ready.
// Ports:
//   i_clk, i_rst            clock, asynchronous active-high reset
//   stream (slave modport)  input column and result column handshakes
//   o_busy                  high whenever the sequencer is not idle
//   o_mulNReadEnable        ROM read enables (N = 9, 11, 13, 14)
//   o_mulNReadAddress       ROM addresses, i.e. the operand byte
//   i_mulNReadData          ROM products, valid ROM_LATENCY cycles later
module inv_mix_column_ctrl #(
  parameter int ROM_LATENCY = 1
) (
  input  logic       i_clk,
  input  logic       i_rst,
  inv_mix_column_ctrl_if.slave stream,
  output logic       o_busy,
  output logic       o_mul9ReadEnable,
  output logic       o_mul11ReadEnable,
  output logic       o_mul13ReadEnable,
  output logic       o_mul14ReadEnable,
  output logic [7:0] o_mul9ReadAddress,
  output logic [7:0] o_mul11ReadAddress,
  output logic [7:0] o_mul13ReadAddress,
  output logic [7:0] o_mul14ReadAddress,
  input  logic [7:0] i_mul9ReadData,
  input  logic [7:0] i_mul11ReadData,
  input  logic [7:0] i_mul13ReadData,
  input  logic [7:0] i_mul14ReadData
);

  typedef enum logic [1:0] {IDLE, ISSUE, DRAIN, HOLD} state_t;

  state_t      r_state;
  state_t      w_nextState;
  logic [31:0] r_operand;
  logic [1:0]  r_k;
  logic [2:0]  r_tagPipe [ROM_LATENCY];
  logic [7:0]  r_resultBytes [4];
  logic [31:0] r_outColumn;

  logic [7:0]  w_opBytes [4];
  logic [1:0]  w_k1;
  logic [1:0]  w_k2;
  logic [1:0]  w_k3;
  logic        w_accept;
  logic        w_tagValid;
  logic [1:0]  w_tagK;
  logic [7:0]  w_product;
  logic        w_lastCapture;

  assign w_opBytes[0] = r_operand[31:24];
  assign w_opBytes[1] = r_operand[23:16];
  assign w_opBytes[2] = r_operand[15:8];
  assign w_opBytes[3] = r_operand[7:0];

  // Byte indices wrap naturally in two bits, giving the mod-4 rotation.
  assign w_k1 = r_k + 2'd1;
  assign w_k2 = r_k + 2'd2;
  assign w_k3 = r_k + 2'd3;

  assign w_accept = (r_state == IDLE) && stream.inValid;

  // The tag leaving the pipe lines up with the ROM data it was issued with.
  assign {w_tagValid, w_tagK} = r_tagPipe[ROM_LATENCY-1];
  assign w_product     = i_mul9ReadData ^ i_mul11ReadData ^ i_mul13ReadData ^ i_mul14ReadData;
  assign w_lastCapture = w_tagValid && (w_tagK == 2'd3);

  // State register.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_nextState;
    end
  end

  // Next-state logic.
  always_comb begin
    w_nextState = r_state;
    case (r_state)
      IDLE:  if (stream.inValid) w_nextState = ISSUE;
      ISSUE: if (r_k == 2'd3) w_nextState = DRAIN;
      DRAIN: if (w_lastCapture) w_nextState = HOLD;
      HOLD:  if (stream.outReady) w_nextState = IDLE;
      default: w_nextState = IDLE;
    endcase
  end

  // Datapath: operand latch, issue counter, capture tag pipe, result bytes.
  // A captured byte overwrites its slot; the published column is kept in a
  // separate register so it stays put while the next column is in flight.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_operand   <= '0;
      r_k         <= '0;
      r_outColumn <= '0;
      for (int i = 0; i < ROM_LATENCY; i++) r_tagPipe[i] <= '0;
      for (int i = 0; i < 4; i++) r_resultBytes[i] <= '0;
    end else begin
      if (w_accept) begin
        r_operand <= stream.inColumn;
        r_k       <= 2'd0;
      end else if (r_state == ISSUE) begin
        r_k <= r_k + 2'd1;
      end

      r_tagPipe[0] <= {(r_state == ISSUE), r_k};
      for (int i = 1; i < ROM_LATENCY; i++) r_tagPipe[i] <= r_tagPipe[i-1];

      if (w_accept) begin
        for (int i = 0; i < 4; i++) r_resultBytes[i] <= '0;
      end else if (w_tagValid) begin
        r_resultBytes[w_tagK] <= w_product;
      end

      // The last byte is taken straight from the ROMs on its capture edge.
      if (w_lastCapture) begin
        r_outColumn <= {r_resultBytes[0], r_resultBytes[1], r_resultBytes[2], w_product};
      end
    end
  end

  // Output logic: handshakes, busy and ROM read ports.
  always_comb begin
    stream.inReady     = (r_state == IDLE);
    stream.outValid    = (r_state == HOLD);
    stream.outColumn   = r_outColumn;
    o_busy             = (r_state != IDLE);
    o_mul9ReadEnable   = 1'b0;
    o_mul11ReadEnable  = 1'b0;
    o_mul13ReadEnable  = 1'b0;
    o_mul14ReadEnable  = 1'b0;
    o_mul9ReadAddress  = 8'h00;
    o_mul11ReadAddress = 8'h00;
    o_mul13ReadAddress = 8'h00;
    o_mul14ReadAddress = 8'h00;
    if (r_state == ISSUE) begin
      o_mul9ReadEnable   = 1'b1;
      o_mul11ReadEnable  = 1'b1;
      o_mul13ReadEnable  = 1'b1;
      o_mul14ReadEnable  = 1'b1;
      o_mul14ReadAddress = w_opBytes[r_k];
      o_mul11ReadAddress = w_opBytes[w_k1];
      o_mul13ReadAddress = w_opBytes[w_k2];
      o_mul9ReadAddress  = w_opBytes[w_k3];
    end
  end

endmodule

// File: tb/tb_inv_mix_column_ctrl.sv
// Self-checking bench for inv_mix_column_ctrl.
// Two instances run side by side, one with ROM_LATENCY=1 and one with
// ROM_LATENCY=3, each served by behavioural multiply ROMs. Results are
// checked against a plain GF(2^8) InvMixColumns model and known vectors.
module tb_inv_mix_column_ctrl;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  logic        tbInValid   [2];
  logic [31:0] tbInColumn  [2];
  logic        tbOutReady  [2];
  logic        tbInReady   [2];
  logic        tbOutValid  [2];
  logic        tbBusy      [2];
  logic [31:0] tbOutColumn [2];
  logic [3:0]  tbEn        [2];
  logic [31:0] tbAddr      [2];

  // GF(2^8) multiply, reduction polynomial 0x11B.
  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] x;
    p = 8'h00;
    x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ x;
      x = x[7] ? ((x << 1) ^ 8'h1B) : (x << 1);
    end
    return p;
  endfunction

  // Reference InvMixColumns on one column, a0 in the top byte.
  function automatic logic [31:0] invMix(input logic [31:0] col);
    logic [7:0]  a [4];
    logic [31:0] r;
    r = 32'h0;
    for (int k = 0; k < 4; k++) a[k] = col[31-8*k -: 8];
    for (int k = 0; k < 4; k++)
      r[31-8*k -: 8] = gmul(a[k], 8'd14) ^ gmul(a[(k+1)%4], 8'd11)
                     ^ gmul(a[(k+2)%4], 8'd13) ^ gmul(a[(k+3)%4], 8'd9);
    return r;
  endfunction

  function automatic int latOf(input int d);
    return (d == 0) ? 1 : 3;
  endfunction

  // Two DUTs, each with its own ROM models of matching latency.
  for (genvar g = 0; g < 2; g++) begin : gDut
    localparam int LAT = (g == 0) ? 1 : 3;
    inv_mix_column_ctrl_if bus ();
    logic        busy;
    logic        e9, e11, e13, e14;
    logic [7:0]  a9, a11, a13, a14;
    logic [31:0] romPipe [LAT];

    assign bus.inValid     = tbInValid[g];
    assign bus.inColumn    = tbInColumn[g];
    assign bus.outReady    = tbOutReady[g];
    assign tbInReady[g]    = bus.inReady;
    assign tbOutValid[g]   = bus.outValid;
    assign tbOutColumn[g]  = bus.outColumn;
    assign tbBusy[g]       = busy;
    assign tbEn[g]         = {e14, e11, e13, e9};
    assign tbAddr[g]       = {a14, a11, a13, a9};

    // Registered ROM reads: product appears LAT edges after the request,
    // zero when the enable was low.
    always @(posedge clk or posedge rst) begin
      if (rst) begin
        for (int i = 0; i < LAT; i++) romPipe[i] <= 32'h0;
      end else begin
        romPipe[0] <= {e14 ? gmul(a14, 8'd14) : 8'h00,
                       e11 ? gmul(a11, 8'd11) : 8'h00,
                       e13 ? gmul(a13, 8'd13) : 8'h00,
                       e9  ? gmul(a9,  8'd9)  : 8'h00};
        for (int i = 1; i < LAT; i++) romPipe[i] <= romPipe[i-1];
      end
    end

    inv_mix_column_ctrl #(.ROM_LATENCY(LAT)) dut (
      .i_clk              (clk),
      .i_rst              (rst),
      .stream             (bus),
      .o_busy             (busy),
      .o_mul9ReadEnable   (e9),
      .o_mul11ReadEnable  (e11),
      .o_mul13ReadEnable  (e13),
      .o_mul14ReadEnable  (e14),
      .o_mul9ReadAddress  (a9),
      .o_mul11ReadAddress (a11),
      .o_mul13ReadAddress (a13),
      .o_mul14ReadAddress (a14),
      .i_mul9ReadData     (romPipe[LAT-1][7:0]),
      .i_mul11ReadData    (romPipe[LAT-1][23:16]),
      .i_mul13ReadData    (romPipe[LAT-1][15:8]),
      .i_mul14ReadData    (romPipe[LAT-1][31:24])
    );
  end

  // Single comparison point: counts every check, reports mismatches.
  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    total++;
    if (observed !== expected) begin
      bad++;
      $display("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
    end
  endtask

  // Idle/reset outputs of one instance.
  task automatic checkIdle(input int d, input logic [31:0] expColumn);
    checkOutput("idleInReady",  32'(tbInReady[d]), 32'd1);
    checkOutput("idleOutValid", 32'(tbOutValid[d]), 32'd0);
    checkOutput("idleOutCol",   tbOutColumn[d], expColumn);
    checkOutput("idleBusy",     32'(tbBusy[d]), 32'd0);
    checkOutput("idleEnables",  32'(tbEn[d]), 32'd0);
    checkOutput("idleAddress",  tbAddr[d], 32'd0);
  endtask

  // One full transaction on instance d. holdCycles>0 keeps outReady low
  // for that many cycles after the result appears.
  task automatic applyStimulus(input int d, input logic [31:0] col,
                               input logic [31:0] expected, input int holdCycles);
    int n;
    tbOutReady[d] = (holdCycles == 0);
    n = 0;
    while (!tbInReady[d] && n < 20) begin
      @(negedge clk);
      n++;
    end
    checkOutput("inReadyWait", 32'(tbInReady[d]), 32'd1);
    @(negedge clk);
    tbInValid[d]  = 1'b1;
    tbInColumn[d] = col;
    @(posedge clk);
    #1;
    tbInValid[d]  = 1'b0;
    tbInColumn[d] = ~col;
    checkOutput("firstIssueAddr", tbAddr[d], col);
    checkOutput("issueEnables",   32'(tbEn[d]), 32'hF);
    checkOutput("issueInReady",   32'(tbInReady[d]), 32'd0);
    n = 0;
    do begin
      @(posedge clk);
      #1;
      n++;
    end while (!tbOutValid[d] && n < 20);
    checkOutput("outValidSeen", 32'(tbOutValid[d]), 32'd1);
    checkOutput("latencyEdges", n, 4 + latOf(d));
    checkOutput("resultColumn", tbOutColumn[d], expected);
    repeat (holdCycles) begin
      @(posedge clk);
      #1;
      checkOutput("holdOutValid", 32'(tbOutValid[d]), 32'd1);
      checkOutput("holdOutCol",   tbOutColumn[d], expected);
      checkOutput("holdInReady",  32'(tbInReady[d]), 32'd0);
      checkOutput("holdEnables",  32'(tbEn[d]), 32'd0);
    end
    if (holdCycles > 0) begin
      @(negedge clk);
      tbOutReady[d] = 1'b1;
    end
    @(posedge clk);
    #1;
    checkOutput("afterOutValid", 32'(tbOutValid[d]), 32'd0);
    checkOutput("afterInReady",  32'(tbInReady[d]), 32'd1);
    checkOutput("afterOutCol",   tbOutColumn[d], expected);
  endtask

  initial begin
    logic [31:0] col;
    logic [31:0] q [$];
    logic [31:0] exp;
    int acceptCyc;
    int outs;

    for (int d = 0; d < 2; d++) begin
      tbInValid[d]  = 1'b0;
      tbInColumn[d] = 32'h0;
      tbOutReady[d] = 1'b0;
    end
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    for (int d = 0; d < 2; d++) checkIdle(d, 32'h0);
    @(negedge clk);
    rst = 1'b0;

    // Known vectors on both latencies.
    for (int d = 0; d < 2; d++) begin
      applyStimulus(d, 32'h8E4DA1BC, 32'hDB135345, 0);
      applyStimulus(d, 32'h9FDC589D, 32'hF20A225C, 0);
      applyStimulus(d, 32'h01010101, 32'h01010101, 0);
      applyStimulus(d, 32'hC6C6C6C6, 32'hC6C6C6C6, 0);
    end

    // Back-pressure on the result.
    applyStimulus(0, 32'h8E4DA1BC, 32'hDB135345, 10);
    applyStimulus(1, 32'h9FDC589D, 32'hF20A225C, 3);

    // Random columns against the model.
    for (int i = 0; i < 6; i++) begin
      for (int d = 0; d < 2; d++) begin
        col = $urandom;
        applyStimulus(d, col, invMix(col), (i == 2) ? 2 : 0);
      end
    end

    // Reset during the third ISSUE cycle of instance 0.
    tbOutReady[0] = 1'b1;
    @(negedge clk);
    tbInValid[0]  = 1'b1;
    tbInColumn[0] = 32'h8E4DA1BC;
    @(posedge clk);
    #1;
    tbInValid[0] = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b1;
    #1;
    checkIdle(0, 32'h0);
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 8; i++) begin
      @(posedge clk);
      #1;
      checkOutput("noStrayValid", 32'(tbOutValid[0]), 32'd0);
    end
    applyStimulus(0, 32'h8E4DA1BC, 32'hDB135345, 0);

    // In_Valid held high with a changing column: each accepted column must
    // come back six negedges later, and the block may be ready only when
    // nothing is outstanding.
    outs = 0;
    acceptCyc = 0;
    tbOutReady[0] = 1'b1;
    tbInValid[0]  = 1'b1;
    for (int c = 0; c < 50; c++) begin
      @(negedge clk);
      if (tbOutValid[0]) begin
        outs++;
        if (q.size() > 0) begin
          exp = q.pop_front();
          checkOutput("streamResult",  tbOutColumn[0], exp);
          checkOutput("streamLatency", c - acceptCyc, 32'd6);
        end else begin
          checkOutput("streamSpurious", 32'(tbOutValid[0]), 32'd0);
        end
      end
      tbInColumn[0] = $urandom;
      if (c >= 40) tbInValid[0] = 1'b0;
      if (tbInReady[0]) begin
        checkOutput("streamReadyIdle", q.size(), 32'd0);
        if (tbInValid[0]) begin
          q.push_back(invMix(tbInColumn[0]));
          acceptCyc = c;
        end
      end
    end
    checkOutput("streamDrained", q.size(), 32'd0);
    checkOutput("streamCount",   outs, 32'd6);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #500000;
    $display("[TB] FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule

// File: doc/inv_mix_column_ctrl.md
Name: inv_mix_column_ctrl

Overview:
- Sequences one AES InvMixColumns column transform through four shared GF(2^8) constant-multiply lookup ROMs (x9, x11, x13, x14).
- The block owns the ROM read ports and drives addresses and enables. It XOR-accumulates the returned products and presents the 32-bit result with valid/ready handshakes.
- Sits between the decryption round state register and the multiply ROMs.
- Each ROM has a registered read of ROM_LATENCY cycles and returns 8'h00 when its Read_Enable is low.

Parameters:
- ROM_LATENCY, 1, cycles from a ROM Read_Enable/Read_Address edge to valid Read_Data; legal range 1..4.

Ports:
- CLK  in  1  system clock; all state updates on rising edge
- RST  in  1  asynchronous, active-high reset
- In_Valid  in  1  input column valid
- In_Ready  out  1  block can accept a column
- In_Column  in  32  a0=[31:24], a1=[23:16], a2=[15:8], a3=[7:0]
- Out_Valid  out  1  result column valid
- Out_Ready  in  1  consumer accepts result
- Out_Column  out  32  b0=[31:24] .. b3=[7:0]
- Busy  out  1  high in any state other than IDLE
- Mul9_Read_Enable / Mul11_Read_Enable / Mul13_Read_Enable / Mul14_Read_Enable  out  1 each  ROM read enables
- Mul9_Read_Address / Mul11_Read_Address / Mul13_Read_Address / Mul14_Read_Address  out  8 each  ROM addresses (operand byte)
- Mul9_Read_Data / Mul11_Read_Data / Mul13_Read_Data / Mul14_Read_Data  in  8 each  ROM products

Behaviour:
- Function: b_k = 14·a_k ^ 11·a_(k+1) ^ 13·a_(k+2) ^ 9·a_(k+3), indices mod 4, GF(2^8) mod 0x11B.
- Reset values:
  - In_Ready=1, Out_Valid=0, Out_Column=0, Busy=0.
  - All ROM enables=0 and all ROM addresses=0.
  - State=IDLE; issue counter=0; capture pipeline cleared.
- States: IDLE, ISSUE, DRAIN, HOLD.
- IDLE:
  - In_Ready=1.
  - On In_Valid: latch In_Column into the operand register, clear the accumulator, go to ISSUE with k=0.
- ISSUE (4 cycles, k=0..3):
  - Assert all four enables.
  - Mul14 addr=a_k, Mul11 addr=a_(k+1), Mul13 addr=a_(k+2), Mul9 addr=a_(k+3).
  - Push tag {valid,k} into a ROM_LATENCY-deep capture shift register.
  - After k=3, go to DRAIN.
  - In_Ready=0.
- Enables and addresses are 0 in all states except ISSUE.
- Capture:
  - When the tag exits the shift register, write the XOR of the four Read_Data into result byte k.
  - Do not OR or accumulate with stale data.
- DRAIN:
  - Enables low; wait until the last tag (k=3) is captured.
  - On that edge set Out_Valid=1, drive Out_Column with the full result, go to HOLD.
- Latency (ROM_LATENCY=1): Out_Valid rises on the 5th rising edge after the accepting edge. In general the edge count is 4+ROM_LATENCY.
- HOLD:
  - Out_Valid=1, Out_Column stable.
  - On Out_Ready: Out_Valid=0 next edge, go to IDLE.
  - In_Ready is 1 only from the following cycle; no back-to-back overlap.
  - Out_Column retains its last value after the handshake until the next result.
- Out_Ready is ignored outside HOLD. In_Valid is ignored outside IDLE, and In_Column changes after acceptance have no effect.
- RST asserted mid-operation (any state): immediately return to reset values. The in-flight column is discarded and no partial Out_Valid pulse occurs.
- Simultaneous In_Valid with Out_Ready in HOLD: In_Valid is not accepted that cycle.

Test Plan:
- In_Column=32'h8E4DA1BC, Out_Ready=1 -> Out_Column=32'hDB135345, Out_Valid high for one cycle exactly 5 edges after accept. In the first ISSUE cycle the addresses are Mul14=8E, Mul11=4D, Mul13=A1, Mul9=BC, and the Mul13 ROM returns 8'h6C.
- In_Column=32'h9FDC589D -> 32'hF20A225C; In_Column=32'h01010101 -> 32'h01010101; In_Column=32'hC6C6C6C6 -> 32'hC6C6C6C6.
- Out_Ready held 0 for 10 cycles after Out_Valid -> Out_Valid and Out_Column stay stable, In_Ready=0, enables low. Raising Out_Ready gives Out_Valid=0 next edge and In_Ready=1 the cycle after.
- RST pulsed during the 3rd ISSUE cycle -> outputs at reset values immediately. A following column 32'h8E4DA1BC still yields 32'hDB135345.
- ROM_LATENCY=3 with matching ROM models -> identical results; Out_Valid 7 edges after accept.
- In_Valid held high continuously with Out_Ready=1 -> one column accepted per transaction, none accepted during ISSUE/DRAIN/HOLD, In_Column changes mid-operation do not corrupt the result.
